// File: rtl/bac_pkg.sv
// bac_pkg: shared state enum, digit constants and digit-extract helper for the Bulls-and-Cows blocks
package bac_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_SCORE, S_WIN, S_LOSE} state_e;
  localparam logic [3:0] DIGIT_PAD = 4'hF;
  localparam int NUM_DIGITS = 4;
  localparam int GUESS_SLOTS = 10;
  function automatic logic [3:0] digit_at(input logic [15:0] v, input int k);
    return v[4*k +: 4];
  endfunction
endpackage

// File: rtl/bac_digit_dup.sv
// bac_digit_dup: flags cand_i if it is above 9 or equals any of the first cnt_i digits of digits_i
module bac_digit_dup
  import bac_pkg::*;
(
  input  logic [15:0] digits_i,
  input  logic [2:0]  cnt_i,
  input  logic [3:0]  cand_i,
  output logic        bad_o
);
  always_comb begin
    bad_o = cand_i > 4'd9;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (k < int'(cnt_i) && digit_at(digits_i, k) == cand_i) bad_o = 1'b1;
  end
endmodule

// File: rtl/bulls_game_ctrl.sv
// bulls_game_ctrl: round sequencer; latches secret, collects keypad guess, drives scorer (sc_guess/sc_answer), captures sc_strike/sc_ball, reports tries/win/lose/errors
module bulls_game_ctrl
  import bac_pkg::*;
#(
  parameter int MAX_TRIES = 10,
  parameter int TW = $clog2(MAX_TRIES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   secret_in,
  input  logic          key_valid,
  input  logic [3:0]    key_digit,
  input  logic          key_enter,
  input  logic          key_clear,
  input  logic [3:0]    sc_strike,
  input  logic [3:0]    sc_ball,
  output logic [39:0]   sc_guess,
  output logic [15:0]   sc_answer,
  output logic [2:0]    entry_cnt,
  output logic [TW-1:0] tries,
  output logic [3:0]    strike,
  output logic [3:0]    ball,
  output logic          result_valid,
  output logic          win,
  output logic          lose,
  output logic          busy,
  output logic          entry_err,
  output logic          cfg_err
);
  state_e state_q, state_d;
  logic [15:0] guess_q, guess_d, ans_q, ans_d;
  logic [2:0] cnt_q, cnt_d;
  logic [TW-1:0] tries_q, tries_d;
  logic [3:0] strike_q, strike_d, ball_q, ball_d;
  logic rv_q, rv_d, eerr_q, eerr_d, cerr_q, cerr_d;
  logic [NUM_DIGITS-1:0] sec_bad;
  logic key_dup, key_bad, sec_ok, last_try;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_sec
    bac_digit_dup u_dup (
      .digits_i(16'({secret_in, secret_in} >> (4 * (i + 1)))),
      .cnt_i   (3'd3),
      .cand_i  (digit_at(secret_in, i)),
      .bad_o   (sec_bad[i])
    );
  end
  bac_digit_dup u_key (
    .digits_i(guess_q),
    .cnt_i   (cnt_q),
    .cand_i  (key_digit),
    .bad_o   (key_dup)
  );
  assign sec_ok   = ~|sec_bad;
  assign key_bad  = key_dup || cnt_q == 3'd4;
  assign last_try = tries_q == TW'(MAX_TRIES - 1);
  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    ans_d    = ans_q;
    cnt_d    = cnt_q;
    tries_d  = tries_q;
    strike_d = strike_q;
    ball_d   = ball_q;
    rv_d     = 1'b0;
    eerr_d   = 1'b0;
    cerr_d   = 1'b0;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE:
        if (start && sec_ok) begin
          ans_d    = secret_in;
          guess_d  = {NUM_DIGITS{DIGIT_PAD}};
          cnt_d    = '0;
          tries_d  = '0;
          strike_d = '0;
          ball_d   = '0;
          state_d  = S_ENTRY;
        end else if (start) begin
          cerr_d = 1'b1;
        end
      S_ENTRY:
        if (key_clear) begin
          cnt_d   = '0;
          guess_d = {NUM_DIGITS{DIGIT_PAD}};
        end else if (key_enter) begin
          state_d = cnt_q == 3'd4 ? S_SCORE : S_ENTRY;
          eerr_d  = cnt_q != 3'd4;
        end else if (key_valid && key_bad) begin
          eerr_d = 1'b1;
        end else if (key_valid) begin
          guess_d[{cnt_q[1:0], 2'b00} +: 4] = key_digit;
          cnt_d = cnt_q + 3'd1;
        end
      S_SCORE: begin
        strike_d = sc_strike;
        ball_d   = sc_ball;
        tries_d  = tries_q + TW'(1);
        rv_d     = 1'b1;
        cnt_d    = '0;
        guess_d  = {NUM_DIGITS{DIGIT_PAD}};
        state_d  = sc_strike == 4'd4 ? S_WIN : last_try ? S_LOSE : S_ENTRY;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      guess_q  <= {NUM_DIGITS{DIGIT_PAD}};
      ans_q    <= '0;
      cnt_q    <= '0;
      tries_q  <= '0;
      strike_q <= '0;
      ball_q   <= '0;
      rv_q     <= 1'b0;
      eerr_q   <= 1'b0;
      cerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      ans_q    <= ans_d;
      cnt_q    <= cnt_d;
      tries_q  <= tries_d;
      strike_q <= strike_d;
      ball_q   <= ball_d;
      rv_q     <= rv_d;
      eerr_q   <= eerr_d;
      cerr_q   <= cerr_d;
    end
  end
  assign sc_guess     = {{(GUESS_SLOTS - NUM_DIGITS){DIGIT_PAD}}, guess_q};
  assign sc_answer    = ans_q;
  assign entry_cnt    = cnt_q;
  assign tries        = tries_q;
  assign strike       = strike_q;
  assign ball         = ball_q;
  assign result_valid = rv_q;
  assign win          = state_q == S_WIN;
  assign lose         = state_q == S_LOSE;
  assign busy         = state_q == S_ENTRY || state_q == S_SCORE;
  assign entry_err    = eerr_q;
  assign cfg_err      = cerr_q;
endmodule

// File: tb/tb_bulls_game_ctrl.sv
// tb_bulls_game_ctrl: scoreboard bench for bulls_game_ctrl with a behavioural scorer in the loop
module tb_bulls_game_ctrl;
  logic clk = 1'b0, rst, start, key_valid, key_enter, key_clear;
  logic [15:0] secret_in;
  logic [3:0] key_digit, sc_strike, sc_ball;
  logic [39:0] sc_guess;
  logic [15:0] sc_answer;
  logic [2:0] entry_cnt;
  logic [3:0] tries, strike, ball;
  logic result_valid, win, lose, busy, entry_err, cfg_err;
  int n_checks = 0, n_fail = 0, m_tries = 0;
  logic [15:0] m_secret;
  typedef struct {logic [3:0] s; logic [3:0] b; int t; logic w; logic l;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  bulls_game_ctrl #(.MAX_TRIES(10)) dut (
    .clk(clk), .rst(rst), .start(start), .secret_in(secret_in),
    .key_valid(key_valid), .key_digit(key_digit), .key_enter(key_enter), .key_clear(key_clear),
    .sc_strike(sc_strike), .sc_ball(sc_ball), .sc_guess(sc_guess), .sc_answer(sc_answer),
    .entry_cnt(entry_cnt), .tries(tries), .strike(strike), .ball(ball),
    .result_valid(result_valid), .win(win), .lose(lose), .busy(busy),
    .entry_err(entry_err), .cfg_err(cfg_err)
  );
  always_comb begin
    sc_strike = 4'd0;
    sc_ball = 4'd0;
    for (int a = 0; a < 4; a++)
      for (int g = 0; g < 10; g++)
        if (sc_guess[4*g +: 4] == sc_answer[4*a +: 4]) begin
          if (a == g) sc_strike = sc_strike + 4'd1;
          else sc_ball = sc_ball + 4'd1;
        end
  end
  always @(negedge clk) begin
    exp_t e;
    if (result_valid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL result_pulse: got result_valid=1 with no result expected");
      end else begin
        e = sb.pop_front();
        if ({strike, ball, tries, win, lose} !== {e.s, e.b, 4'(e.t), e.w, e.l}) begin
          n_fail++;
          $display("FAIL result: got strike=%0d ball=%0d tries=%0d win=%b lose=%b exp strike=%0d ball=%0d tries=%0d win=%b lose=%b",
                   strike, ball, tries, win, lose, e.s, e.b, e.t, e.w, e.l);
        end
      end
    end
  end
  function automatic void score(input logic [15:0] sec, input logic [15:0] g, output logic [3:0] s, output logic [3:0] b);
    s = 0;
    b = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (sec[4*i +: 4] == g[4*j +: 4]) begin
          if (i == j) s = s + 4'd1;
          else b = b + 4'd1;
        end
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    tick();
    key_valid = 1'b0;
  endtask
  task automatic do_start(input logic [15:0] s);
    start = 1'b1;
    secret_in = s;
    tick();
    start = 1'b0;
  endtask
  task automatic submit(input logic [15:0] g);
    exp_t e;
    int n;
    score(m_secret, g, e.s, e.b);
    m_tries++;
    e.t = m_tries;
    e.w = e.s == 4'd4;
    e.l = e.s != 4'd4 && m_tries == 10;
    sb.push_back(e);
    key_enter = 1'b1;
    tick();
    key_enter = 1'b0;
    n = 1;
    while (result_valid !== 1'b1 && n < 6) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != 2) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles exp 2", n);
    end
  endtask
  task automatic guess(input logic [15:0] g);
    for (int k = 0; k < 4; k++) press(g[4*k +: 4]);
    n_checks++;
    if (entry_cnt !== 3'd4) begin
      n_fail++;
      $display("FAIL guess_cnt: got %0d exp 4", entry_cnt);
    end
    submit(g);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks += 2;
    if (sc_guess !== 40'hFF_FFFF_FFFF) begin n_fail++; $display("FAIL reset_guess: got %h exp ffffffffff", sc_guess); end
    if ({sc_answer, entry_cnt, tries, strike, ball, result_valid, win, lose, busy, entry_err, cfg_err} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ans=%h cnt=%0d tries=%0d s=%0d b=%0d rv=%b w=%b l=%b busy=%b ee=%b ce=%b exp all 0",
               sc_answer, entry_cnt, tries, strike, ball, result_valid, win, lose, busy, entry_err, cfg_err);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got busy=%b exp 0", busy); end
  endtask
  task automatic test_cfg();
    do_start(16'h1123);
    n_checks += 2;
    if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_dup: got cfg_err=%b exp 1", cfg_err); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL cfg_dup_state: got busy=%b exp 0", busy); end
    do_start(16'h12A3);
    n_checks += 2;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL cfg_range: got cfg_err=%b busy=%b exp 1 0", cfg_err, busy); end
    if (sc_answer !== 16'h0) begin n_fail++; $display("FAIL cfg_answer: got %h exp 0000", sc_answer); end
    do_start(16'h9876);
    m_secret = 16'h9876;
    n_checks += 2;
    if (busy !== 1'b1 || cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_ok: got busy=%b cfg_err=%b exp 1 0", busy, cfg_err); end
    if (sc_answer !== 16'h9876) begin n_fail++; $display("FAIL cfg_latch: got %h exp 9876", sc_answer); end
  endtask
  task automatic test_entry();
    press(4'd5);
    press(4'd5);
    n_checks++;
    if (entry_err !== 1'b1 || entry_cnt !== 3'd1) begin n_fail++; $display("FAIL entry_dup: got err=%b cnt=%0d exp 1 1", entry_err, entry_cnt); end
    press(4'hA);
    n_checks++;
    if (entry_err !== 1'b1 || entry_cnt !== 3'd1) begin n_fail++; $display("FAIL entry_range: got err=%b cnt=%0d exp 1 1", entry_err, entry_cnt); end
    press(4'd6);
    press(4'd7);
    n_checks++;
    if (sc_guess !== 40'hFF_FFFF_F765) begin n_fail++; $display("FAIL entry_guess: got %h exp fffffff765", sc_guess); end
    key_enter = 1'b1;
    tick();
    key_enter = 1'b0;
    n_checks++;
    if (entry_err !== 1'b1) begin n_fail++; $display("FAIL enter_short: got err=%b exp 1", entry_err); end
    tick();
    n_checks++;
    if (entry_cnt !== 3'd3 || tries !== 4'd0) begin n_fail++; $display("FAIL enter_noscore: got cnt=%0d tries=%0d exp 3 0", entry_cnt, tries); end
    start = 1'b1;
    secret_in = 16'h4321;
    tick();
    start = 1'b0;
    n_checks++;
    if (sc_answer !== 16'h9876 || entry_cnt !== 3'd3 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored: got ans=%h cnt=%0d ce=%b exp 9876 3 0", sc_answer, entry_cnt, cfg_err);
    end
    press(4'd8);
    press(4'd9);
    n_checks++;
    if (entry_err !== 1'b1 || sc_guess[15:0] !== 16'h8765) begin n_fail++; $display("FAIL entry_full: got err=%b guess=%h exp 1 8765", entry_err, sc_guess[15:0]); end
  endtask
  task automatic test_clear_enter();
    key_clear = 1'b1;
    key_enter = 1'b1;
    tick();
    key_clear = 1'b0;
    key_enter = 1'b0;
    n_checks++;
    if (entry_cnt !== 3'd0 || sc_guess !== 40'hFF_FFFF_FFFF || entry_err !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_enter: got cnt=%0d guess=%h err=%b exp 0 ffffffffff 0", entry_cnt, sc_guess, entry_err);
    end
    tick();
    tick();
    n_checks++;
    if (tries !== 4'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL clear_noscore: got tries=%0d busy=%b exp 0 1", tries, busy); end
  endtask
  task automatic test_win();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do_start(16'h4321);
    m_secret = 16'h4321;
    m_tries = 0;
    guess(16'h4321);
    n_checks++;
    if (win !== 1'b1 || busy !== 1'b0 || tries !== 4'd1) begin n_fail++; $display("FAIL win: got win=%b busy=%b tries=%0d exp 1 0 1", win, busy, tries); end
    press(4'd1);
    n_checks++;
    if (win !== 1'b1 || result_valid !== 1'b0 || entry_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL win_hold: got win=%b rv=%b cnt=%0d exp 1 0 0", win, result_valid, entry_cnt);
    end
  endtask
  task automatic test_lose();
    logic [15:0] gl [9] = '{16'h8765, 16'h3421, 16'h7651, 16'h0598, 16'h2143, 16'h5678, 16'h9012, 16'h4312, 16'h0987};
    do_start(16'h4321);
    m_tries = 0;
    n_checks++;
    if (tries !== 4'd0 || strike !== 4'd0 || win !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart: got tries=%0d strike=%0d win=%b busy=%b exp 0 0 0 1", tries, strike, win, busy);
    end
    guess(16'h1234);
    n_checks++;
    if (busy !== 1'b1 || lose !== 1'b0) begin n_fail++; $display("FAIL back_to_entry: got busy=%b lose=%b exp 1 0", busy, lose); end
    foreach (gl[i]) guess(gl[i]);
    n_checks++;
    if (lose !== 1'b1 || tries !== 4'd10 || busy !== 1'b0) begin n_fail++; $display("FAIL lose: got lose=%b tries=%0d busy=%b exp 1 10 0", lose, tries, busy); end
    press(4'd1);
    n_checks++;
    if (lose !== 1'b1 || tries !== 4'd10 || entry_cnt !== 3'd0) begin n_fail++; $display("FAIL lose_hold: got lose=%b tries=%0d cnt=%0d exp 1 10 0", lose, tries, entry_cnt); end
  endtask
  task automatic test_reset_in_score();
    do_start(16'h4321);
    press(4'd1);
    press(4'd2);
    press(4'd3);
    press(4'd5);
    key_enter = 1'b1;
    tick();
    key_enter = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL score_state: got busy=%b exp 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({sc_guess, sc_answer, entry_cnt, tries, strike, ball, result_valid, win, lose, busy, entry_err, cfg_err} !== {40'hFF_FFFF_FFFF, 37'd0}) begin
      n_fail++;
      $display("FAIL rst_score: got guess=%h ans=%h cnt=%0d tries=%0d s=%0d rv=%b busy=%b exp reset values",
               sc_guess, sc_answer, entry_cnt, tries, strike, result_valid, busy);
    end
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0 || tries !== 4'd0) begin n_fail++; $display("FAIL rst_score_idle: got busy=%b tries=%0d exp 0 0", busy, tries); end
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    key_valid = 1'b0;
    key_enter = 1'b0;
    key_clear = 1'b0;
    secret_in = 16'h0;
    key_digit = 4'h0;
    test_reset();
    test_cfg();
    test_entry();
    test_clear_enter();
    test_win();
    test_lose();
    test_reset_in_score();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending exp 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bulls_game_ctrl.md
# bulls_game_ctrl

Round sequencer for the Bulls-and-Cows scorer. It latches a 4-digit secret, collects a 4-digit guess from the keypad, and presents guess and answer to the combinational scorer. It captures the strike/ball result, counts attempts, and declares win or loss. It sits between the keypad decoder and the display/LCD driver, and owns the scorer's `guess`/`answer` inputs.

## Interface
- `MAX_TRIES`, default 10: attempts allowed per game, legal range 1..15.
- `TW`, default `$clog2(MAX_TRIES+1)`: width of the attempt counter.
- `clk` in 1: single clock. Reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: load `secret_in` and begin a game. Honoured only in IDLE, WIN or LOSE.
- `secret_in` in 16: four BCD digits. Digit k is `[4k+3:4k]`.
- `key_valid` in 1: one-cycle strobe; `key_digit` is valid.
- `key_digit` in 4: keypad value.
- `key_enter` in 1: one-cycle strobe; submit the guess.
- `key_clear` in 1: one-cycle strobe; discard the partial guess.
- `sc_strike` in 4: scorer strike count, combinational from `sc_guess`/`sc_answer`.
- `sc_ball` in 4: scorer ball count, combinational from `sc_guess`/`sc_answer`.
- `sc_guess` out 40: registered. Digits 0..3 are the entered guess; digits 4..9 are always `4'hF`.
- `sc_answer` out 16: registered latched secret.
- `entry_cnt` out 3: digits entered so far, 0..4.
- `tries` out TW: completed attempts.
- `strike` out 4: last captured strike count.
- `ball` out 4: last captured ball count.
- `result_valid` out 1: one-cycle pulse when `strike`/`ball` update.
- `win` out 1: level, asserted in WIN.
- `lose` out 1: level, asserted in LOSE.
- `busy` out 1: asserted in ENTRY or SCORE.
- `entry_err` out 1: one-cycle pulse on a rejected key.
- `cfg_err` out 1: one-cycle pulse on a rejected secret.

## Operation
- States are IDLE, ENTRY, SCORE, WIN and LOSE.
- Reset state is IDLE. All outputs are 0 on reset, except `sc_guess` = `40'hFFFF_FFFF_FF`.
- **start** (IDLE/WIN/LOSE):
  - The secret is valid when every digit is ≤ 9 and all four digits are distinct.
  - Valid secret: latch it into `sc_answer`, clear `tries`, `strike`, `ball` and `entry_cnt`, and set `sc_guess` digits 0..3 to `F`. Go to ENTRY.
  - Invalid secret: pulse `cfg_err`; state and all registers are unchanged.
  - `start` in ENTRY or SCORE is ignored.
- **ENTRY**:
  - `key_valid` with a digit ≤ 9, not already entered, and `entry_cnt` < 4: write the digit to `sc_guess` digit `entry_cnt`, then increment `entry_cnt`.
  - Any other `key_valid` (digit > 9, duplicate, or buffer full): pulse `entry_err`, no change.
  - `key_enter` with `entry_cnt` == 4: go to SCORE.
  - `key_enter` with `entry_cnt` < 4: pulse `entry_err`.
  - `key_clear`: `entry_cnt` ← 0 and guess digits 0..3 ← `F`.
- **Simultaneous strobes** in the same cycle, priority: `key_clear` > `key_enter` > `key_valid`. Lower-priority strobes are dropped silently.
- **SCORE** (exactly one cycle; all keys ignored):
  - Capture `strike` ← `sc_strike` and `ball` ← `sc_ball`.
  - `tries` ← `tries` + 1.
  - Pulse `result_valid` in the following cycle.
  - Reset `entry_cnt` to 0 and guess digits 0..3 to `F`.
  - Next state: `sc_strike` == 4 → WIN; else if `tries`+1 == MAX_TRIES → LOSE; else ENTRY. WIN takes priority on the last try.
- **WIN/LOSE**: hold `strike`, `ball` and `tries`. Only `start` leaves these states.
- **Padding**: the `F` digits never equal a BCD answer digit, so padding contributes no strikes or balls.

## Timing
- `key_enter` accepted in cycle N → SCORE in N+1 → `result_valid`, new `strike`/`ball`/`tries`, and the next state all visible in N+2.
- The scorer must settle within one cycle. `sc_guess` is stable from the cycle after the fourth digit write until SCORE ends.
- Key acceptance rate is one key per cycle. Back-to-back strobes are all processed.
- `entry_err` and `cfg_err` pulse in the cycle after the offending strobe.
- `rst` in any state, including mid-SCORE, wins over every input. `result_valid` is not emitted for a game aborted by reset.

## Structure
- Shared package `bac_pkg`:
  - state enum.
  - `DIGIT_PAD` = `4'hF`.
  - `NUM_DIGITS` = 4.
  - `GUESS_SLOTS` = 10.
  - digit-extract helper.
- Sub-module `bac_digit_dup`: combinational. Inputs are a 4-digit vector, a valid-count and a candidate digit; output is "duplicate or out of range". It is reused for secret validation (count = 3, one check per digit) and for key entry.
- The scorer is instantiated by the parent. This block only drives and samples it.

## Test plan
- Secret `16'h4321`, keys 1,2,3,4, enter → `result_valid` at N+2 with strike=4, ball=0; `win`=1; `tries`=1.
- Secret `16'h4321`, guess 4,3,2,1 → strike=0, ball=4, back to ENTRY. Repeat wrong guesses until MAX_TRIES=10 → `lose`=1, `tries`=10.
- Keys 5, 5 → second key pulses `entry_err` and `entry_cnt` stays 1. Key `4'hA` → `entry_err`. Enter with 3 digits → `entry_err` and no SCORE.
- `start` with secret `16'h1123` or `16'h12A3` → `cfg_err` and state stays IDLE. Then `start` with `16'h9876` → ENTRY.
- Same cycle `key_clear` + `key_enter` with 4 digits entered → `entry_cnt`=0, no scoring. `start` during ENTRY ignored.
- `rst` asserted in the SCORE cycle → IDLE next cycle, no `result_valid`, `tries`=0, all outputs at reset values.
